// File: rtl/rx_frame_pkg.sv
// Shared types for the receive frame buffer sequencer.
// Pixel layout and FSM states used by controller and packer.
package rx_frame_pkg;

  typedef enum logic {
    S_RECV,
    S_READ
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int BYTES_PER_PIXEL = 3;

endpackage

// File: rtl/rx_pixel_packer.sv
// Packs R,G,B bytes into one pixel strobe.
// Also watches for stalled partial frames.
module rx_pixel_packer
  import rx_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       frame_open,
  output logic       pixel_valid,
  output rgb_t       pixel,
  output logic       timeout
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] LAST_SLOT = 2'(BYTES_PER_PIXEL - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        byte_cnt;
  logic [7:0]        r_q;
  logic [7:0]        g_q;
  logic [IDLE_W-1:0] idle_cnt;
  logic              counting;

  assign counting = (frame_open || byte_cnt != 2'd0) && !byte_valid;
  assign timeout = counting && (idle_cnt == IDLE_MAX);
  assign pixel_valid = byte_valid && (byte_cnt == LAST_SLOT);
  assign pixel = '{r: r_q, g: g_q, b: byte_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      r_q      <= 8'd0;
      g_q      <= 8'd0;
      idle_cnt <= '0;
    end else if (byte_valid) begin
      idle_cnt <= '0;
      unique case (1'b1)
        byte_cnt == 2'd0: begin
          r_q      <= byte_data;
          byte_cnt <= 2'd1;
        end
        byte_cnt == 2'd1: begin
          g_q      <= byte_data;
          byte_cnt <= 2'd2;
        end
        default: byte_cnt <= 2'd0;
      endcase
    end else if (timeout) begin
      byte_cnt <= 2'd0;
      idle_cnt <= '0;
    end else if (counting) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame buffer sequencer: UART bytes into RAM,
// then the stored frame streamed out over valid/ready.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int RGB_WIDTH      = 24,
  parameter int IMG_WIDTH      = 80,
  parameter int IMG_HEIGHT     = 120,
  parameter int TOTAL_PIXELS   = IMG_WIDTH * IMG_HEIGHT,
  parameter int ADDR_WIDTH     = $clog2(TOTAL_PIXELS),
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  ram_we,
  output logic [RGB_WIDTH-1:0]  ram_wData,
  output logic [ADDR_WIDTH-1:0] ram_wAddr,
  output logic                  ram_frame_done,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_rAddr,
  input  logic [RGB_WIDTH-1:0]  ram_imgData,
  output logic                  pix_valid,
  output logic [RGB_WIDTH-1:0]  pix_data,
  output logic                  pix_last,
  input  logic                  pix_ready,
  output logic                  rx_drop,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(TOTAL_PIXELS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_end;
  logic                  accept;
  logic                  pixel_valid;
  rgb_t                  pixel;
  logic                  timeout;
  logic                  frame_open;
  logic                  load;
  logic                  last_hs;

  assign accept = rx_valid && (state == S_RECV);
  assign frame_open = (state == S_RECV) && (pix_cnt != '0);

  rx_pixel_packer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (accept),
    .byte_data  (rx_data),
    .frame_open (frame_open),
    .pixel_valid(pixel_valid),
    .pixel      (pixel),
    .timeout    (timeout)
  );

  assign ram_we = pixel_valid;
  assign ram_wData = pixel_valid ? pixel : '0;
  assign ram_wAddr = pix_cnt;
  assign ram_oe = (state == S_READ);
  assign ram_rAddr = rd_ptr;
  assign busy = (state == S_READ);

  // rd_end marks that the last address has been loaded
  assign load = !rd_end && (!pix_valid || pix_ready);
  assign last_hs = pix_valid && pix_ready && pix_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_RECV;
      pix_cnt        <= '0;
      rd_ptr         <= '0;
      rd_end         <= 1'b0;
      pix_valid      <= 1'b0;
      pix_data       <= '0;
      pix_last       <= 1'b0;
      ram_frame_done <= 1'b0;
      rx_drop        <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      ram_frame_done <= 1'b0;
      rx_drop        <= rx_valid && (state == S_READ);
      timeout_err    <= timeout;
      unique case (state)
        S_RECV: begin
          if (pixel_valid) begin
            if (pix_cnt == LAST) begin
              pix_cnt        <= '0;
              ram_frame_done <= 1'b1;
              state          <= S_READ;
            end else begin
              pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
            end
          end else if (timeout) begin
            pix_cnt <= '0;
          end
        end
        S_READ: begin
          if (last_hs) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            rd_ptr    <= '0;
            rd_end    <= 1'b0;
            state     <= S_RECV;
          end else if (load) begin
            pix_data  <= ram_imgData;
            pix_valid <= 1'b1;
            pix_last  <= (rd_ptr == LAST);
            if (rd_ptr == LAST) rd_end <= 1'b1;
            else rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
          end else if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
          end
        end
        default: state <= S_RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl on an 8-pixel frame.
// RAM is modelled here; checks go through one task.
module tb_rx_frame_ctrl;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          ram_we;
  logic [23:0]   ram_wData;
  logic [AW-1:0] ram_wAddr;
  logic          ram_frame_done;
  logic          ram_oe;
  logic [AW-1:0] ram_rAddr;
  logic [23:0]   ram_imgData;
  logic          pix_valid;
  logic [23:0]   pix_data;
  logic          pix_last;
  logic          pix_ready = 1'b1;
  logic          rx_drop;
  logic          timeout_err;
  logic          busy;

  rx_frame_ctrl #(
    .RGB_WIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_we(ram_we), .ram_wData(ram_wData),
    .ram_wAddr(ram_wAddr),
    .ram_frame_done(ram_frame_done),
    .ram_oe(ram_oe), .ram_rAddr(ram_rAddr),
    .ram_imgData(ram_imgData),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last(pix_last), .pix_ready(pix_ready),
    .rx_drop(rx_drop), .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [8];
  assign ram_imgData = ram_oe ? mem[ram_rAddr] : 24'd0;
  always @(posedge clk) if (ram_we) mem[ram_wAddr] <= ram_wData;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0, fd_cnt = 0, drop_cnt = 0, to_cnt = 0;
  int excl_viol = 0, we_bad = 0, stall_viol = 0;
  int fd_cyc = 0;
  int rdy_mode = 0;
  logic [3:0] pat = 4'b1001;
  logic stalled = 1'b0;
  logic [24:0] held = '0;
  logic [23:0] wq_data[$];
  int wq_addr[$];
  logic [23:0] bq_data[$];
  logic bq_last[$];
  int bq_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (ram_we) begin
        wr_cnt++;
        wq_addr.push_back(int'(ram_wAddr));
        wq_data.push_back(ram_wData);
      end
      if (ram_frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (rx_drop) drop_cnt++;
      if (timeout_err) to_cnt++;
      if (int'(ram_frame_done) + int'(rx_drop) + int'(timeout_err) > 1)
        excl_viol++;
      if (ram_we && busy) we_bad++;
      if (pix_valid && pix_ready) begin
        bq_data.push_back(pix_data);
        bq_last.push_back(pix_last);
        bq_cyc.push_back(cyc);
      end
      if (stalled && (!pix_valid || {pix_last, pix_data} !== held))
        stall_viol++;
      stalled = pix_valid && !pix_ready;
      held = {pix_last, pix_data};
    end else begin
      stalled = 1'b0;
    end
  end

  always @(negedge clk) begin
    case (rdy_mode)
      1: pix_ready = pat[cyc % 4];
      2: pix_ready = 1'b0;
      default: pix_ready = 1'b1;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] px(input logic [7:0] base, input int i);
    logic [7:0] r;
    r = base + 8'(3 * i);
    return {r, r + 8'd1, r + 8'd2};
  endfunction

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    bq_data.delete();
    bq_last.delete();
    bq_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < 24; i++) send_byte(base + 8'(i), 3);
  endtask

  task automatic wait_readout(input string tag);
    int n = 0;
    while (!(bq_data.size() >= 8 && !busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(n < 400), 32'd1);
  endtask

  task automatic check_writes(input string tag, input logic [7:0] base);
    check({tag, "_nwr"}, 32'(wq_data.size()), 32'd8);
    for (int i = 0; i < wq_data.size() && i < 8; i++) begin
      check($sformatf("%s_wa%0d", tag, i), 32'(wq_addr[i]), 32'(i));
      check($sformatf("%s_wd%0d", tag, i), 32'(wq_data[i]), 32'(px(base, i)));
    end
  endtask

  task automatic check_beats(input string tag, input logic [7:0] base);
    check({tag, "_nbeat"}, 32'(bq_data.size()), 32'd8);
    for (int i = 0; i < bq_data.size() && i < 8; i++) begin
      check($sformatf("%s_bd%0d", tag, i), 32'(bq_data[i]), 32'(px(base, i)));
      check($sformatf("%s_bl%0d", tag, i), 32'(bq_last[i]), 32'(i == 7));
    end
  endtask

  initial begin
    int wr0, to0, dr0, fd0, n;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_oe", 32'(ram_oe), 0);
    check("rst_we", 32'(ram_we), 0);
    check("rst_fd", 32'(ram_frame_done), 0);
    rst_n = 1'b1;

    // 1: plain frame, ready held high
    clear_q();
    fd0 = fd_cnt;
    send_frame(8'h00);
    wait_readout("s1");
    check_writes("s1", 8'h00);
    check_beats("s1", 8'h00);
    check("s1_fd", 32'(fd_cnt - fd0), 1);
    if (bq_cyc.size() >= 8) begin
      check("s1_first", 32'(bq_cyc[0] - fd_cyc), 1);
      check("s1_burst", 32'(bq_cyc[7] - bq_cyc[0]), 7);
    end else check("s1_cyc", 32'(bq_cyc.size()), 8);
    check("s1_idle", 32'(busy), 0);

    // 2: same frame under back-pressure
    clear_q();
    rdy_mode = 1;
    send_frame(8'h00);
    wait_readout("s2");
    rdy_mode = 0;
    check_beats("s2", 8'h00);

    // 3: partial frame times out, next frame restarts at 0
    clear_q();
    wr0 = wr_cnt;
    to0 = to_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 3);
    repeat (20) @(negedge clk);
    check("s3_to", 32'(to_cnt - to0), 1);
    check("s3_wr", 32'(wr_cnt - wr0), 1);
    clear_q();
    send_frame(8'hA0);
    wait_readout("s3");
    check_writes("s3", 8'hA0);
    check_beats("s3", 8'hA0);

    // 4: bytes during readout are dropped
    clear_q();
    rdy_mode = 2;
    send_frame(8'h40);
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s4_busy", 32'(busy), 1);
    wr0 = wr_cnt;
    dr0 = drop_cnt;
    send_byte(8'h55, 1);
    send_byte(8'h66, 1);
    send_byte(8'h77, 1);
    check("s4_drop", 32'(drop_cnt - dr0), 3);
    check("s4_wr", 32'(wr_cnt - wr0), 0);
    rdy_mode = 0;
    wait_readout("s4");
    check_beats("s4", 8'h40);
    clear_q();
    send_frame(8'h80);
    wait_readout("s4b");
    check_writes("s4b", 8'h80);

    // 5: reset in the middle of readout
    clear_q();
    send_frame(8'h10);
    n = 0;
    while (bq_data.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("s5_beats", 32'(bq_data.size()), 3);
    rst_n = 1'b0;
    #1;
    check("s5_valid", 32'(pix_valid), 0);
    check("s5_data", 32'(pix_data), 0);
    check("s5_last", 32'(pix_last), 0);
    check("s5_oe", 32'(ram_oe), 0);
    check("s5_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    send_frame(8'h20);
    wait_readout("s5");
    check_writes("s5", 8'h20);
    check_beats("s5", 8'h20);

    // 6: long idle with an empty frame
    wr0 = wr_cnt;
    to0 = to_cnt;
    repeat (100) @(negedge clk);
    check("s6_to", 32'(to_cnt - to0), 0);
    check("s6_wr", 32'(wr_cnt - wr0), 0);
    check("s6_busy", 32'(busy), 0);

    check("excl", 32'(excl_viol), 0);
    check("we_read", 32'(we_bad), 0);
    check("stall", 32'(stall_viol), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
